// File: rtl/spi_sub.sv
// SPI subordinate (mode 3): decodes RW/address/data frames onto a simple register bus.
// sclk, cs_n and mosi are oversampled in the clk domain and edge-detected there.
module spi_sub #(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MSB_FIRST   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_rvalid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(MAX_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RW      = 3'd1,
    S_ADDR    = 3'd2,
    S_DATA    = 3'd3,
    S_WAIT_CS = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  logic w_sclk_s;
  logic w_cs_s;
  logic w_mosi_s;
  logic w_rise;
  logic w_fall;
  logic w_cs_fall;
  logic w_cs_rise;

  state_t                r_state;
  logic                  r_rw;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr_sr;
  logic [DATA_WIDTH-1:0] r_data_sr;
  logic [DATA_WIDTH-1:0] r_tx_sr;
  logic                  r_loaded;
  logic                  r_win;
  logic                  r_first_fall;
  logic                  r_re_pend;
  logic                  r_we_pend;

  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [DATA_WIDTH-1:0] w_data_next;
  logic [DATA_WIDTH-1:0] w_tx_shift;
  logic                  w_tx_bit;

  // Synchronize the SPI pins and keep the previous synchronized sample for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '1;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b1;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise    = w_sclk_s & ~r_sclk_d;
  assign w_fall    = ~w_sclk_s & r_sclk_d;
  assign w_cs_fall = ~w_cs_s & r_cs_d;
  assign w_cs_rise = w_cs_s & ~r_cs_d;

  // Shift-register next values in the configured bit order
  always_comb begin
    w_addr_next = '0;
    w_data_next = '0;
    w_tx_shift  = '0;
    w_tx_bit    = 1'b0;
    if (MSB_FIRST != 0) begin
      w_addr_next = {r_addr_sr[ADDR_WIDTH-2:0], w_mosi_s};
      w_data_next = {r_data_sr[DATA_WIDTH-2:0], w_mosi_s};
      w_tx_shift  = {r_tx_sr[DATA_WIDTH-2:0], 1'b0};
      w_tx_bit    = r_tx_sr[DATA_WIDTH-1];
    end else begin
      w_addr_next = {w_mosi_s, r_addr_sr[ADDR_WIDTH-1:1]};
      w_data_next = {w_mosi_s, r_data_sr[DATA_WIDTH-1:1]};
      w_tx_shift  = {1'b0, r_tx_sr[DATA_WIDTH-1:1]};
      w_tx_bit    = r_tx_sr[0];
    end
  end

  // Frame decode state machine with registered bus strobes and SPI outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rw         <= 1'b0;
      r_cnt        <= '0;
      r_addr_sr    <= '0;
      r_data_sr    <= '0;
      r_tx_sr      <= '0;
      r_loaded     <= 1'b0;
      r_win        <= 1'b0;
      r_first_fall <= 1'b0;
      r_re_pend    <= 1'b0;
      r_we_pend    <= 1'b0;
      miso         <= 1'b0;
      miso_oe      <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      reg_we       <= 1'b0;
      reg_re       <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      frame_err <= 1'b0;
      r_re_pend <= 1'b0;
      r_we_pend <= 1'b0;

      // Strobes fire one clk after the address/data register update; read window opens with reg_re
      if (r_re_pend) begin
        reg_re <= 1'b1;
        r_win  <= 1'b1;
      end
      if (r_we_pend) begin
        reg_we <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          miso    <= 1'b0;
          miso_oe <= 1'b0;
          if (w_cs_fall) begin
            busy         <= 1'b1;
            r_addr_sr    <= '0;
            r_data_sr    <= '0;
            r_tx_sr      <= '0;
            r_loaded     <= 1'b0;
            r_win        <= 1'b0;
            r_first_fall <= 1'b0;
            r_state      <= S_RW;
          end
        end

        S_RW: begin
          if (w_cs_rise) begin
            frame_err <= 1'b1;
            miso_oe   <= 1'b0;
            miso      <= 1'b0;
            busy      <= 1'b0;
            r_win     <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_rise) begin
            r_rw    <= w_mosi_s;
            r_cnt   <= CNT_W'(ADDR_WIDTH - 1);
            r_state <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (w_cs_rise) begin
            frame_err <= 1'b1;
            miso_oe   <= 1'b0;
            miso      <= 1'b0;
            busy      <= 1'b0;
            r_win     <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_rise) begin
            r_addr_sr <= w_addr_next;
            if (r_cnt == '0) begin
              reg_addr <= w_addr_next;
              if (!r_rw) begin
                r_re_pend <= 1'b1;
                miso_oe   <= 1'b1;
              end
              r_cnt   <= CNT_W'(DATA_WIDTH - 1);
              r_state <= S_DATA;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end

        S_DATA: begin
          if (w_cs_rise) begin
            frame_err <= 1'b1;
            miso_oe   <= 1'b0;
            miso      <= 1'b0;
            busy      <= 1'b0;
            r_win     <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            // Read: capture response before the first fall, then shift it out on falls
            if (!r_rw) begin
              if (w_fall) begin
                r_win        <= 1'b0;
                r_first_fall <= 1'b1;
                if (!r_first_fall && !r_loaded) begin
                  frame_err <= 1'b1;
                  miso      <= 1'b0;
                end else begin
                  miso    <= w_tx_bit;
                  r_tx_sr <= w_tx_shift;
                end
              end else if (r_win && reg_rvalid && !r_loaded) begin
                r_tx_sr  <= reg_rdata;
                r_loaded <= 1'b1;
                r_win    <= 1'b0;
              end
            end
            if (w_rise) begin
              if (r_rw) begin
                r_data_sr <= w_data_next;
              end
              if (r_cnt == '0) begin
                if (r_rw) begin
                  reg_wdata <= w_data_next;
                  r_we_pend <= 1'b1;
                end
                miso_oe <= 1'b0;
                miso    <= 1'b0;
                r_state <= S_WAIT_CS;
              end else begin
                r_cnt <= r_cnt - CNT_W'(1);
              end
            end
          end
        end

        S_WAIT_CS: begin
          miso    <= 1'b0;
          miso_oe <= 1'b0;
          if (w_cs_rise) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          miso    <= 1'b0;
          miso_oe <= 1'b0;
          busy    <= 1'b0;
          r_win   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
